// File: rtl/mips150_io_ctrl.sv
// MIPS150 memory-mapped IO: UART TX, UART RX with FIFO, cycle counter.
// Define IO_CYCLE_COUNTER_EN to build the cycle counter at offset 0x10.
module mips150_io_ctrl #(
    parameter int CLKS_PER_BIT  = 868,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  addr,
    input  logic [3:0]  store_mask,
    input  logic        load_sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(RX_FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } uartState_t;

    logic unusedBits;
    assign unusedBits = ^{addr[1:0], wdata[31:8]};

    logic [5:0] regIdx;
    logic       wrAccess;
    logic       rdAccess;
    logic       selTxStat;
    logic       selRxStat;
    logic       selTxData;
    logic       selRxData;

    assign regIdx    = addr[7:2];
    assign wrAccess  = |store_mask;
    assign rdAccess  = load_sel && !wrAccess;
    assign selTxStat = (regIdx == 6'd0);
    assign selRxStat = (regIdx == 6'd1);
    assign selTxData = (regIdx == 6'd2);
    assign selRxData = (regIdx == 6'd3);

    // ---------------- UART transmitter ----------------
    uartState_t txState, txStateNext;
    logic [CW-1:0] txCnt, txCntNext;
    logic [2:0]    txBitIdx, txBitIdxNext;
    logic [7:0]    txShift, txShiftNext;
    logic          txLine;
    logic          txReady;
    logic          txWrite;

    assign txReady = (txState == S_IDLE);
    assign txWrite = wrAccess && selTxData;

    always_ff @(posedge clk) begin
        if (rst) begin
            txState  <= S_IDLE;
            txCnt    <= '0;
            txBitIdx <= '0;
            txShift  <= '0;
            uart_tx  <= 1'b1;
        end else begin
            txState  <= txStateNext;
            txCnt    <= txCntNext;
            txBitIdx <= txBitIdxNext;
            txShift  <= txShiftNext;
            uart_tx  <= txLine;
        end
    end

    always_comb begin
        txStateNext  = txState;
        txCntNext    = txCnt;
        txBitIdxNext = txBitIdx;
        txShiftNext  = txShift;
        txLine       = 1'b1;
        unique case (txState)
            S_IDLE: begin
                if (txWrite) begin
                    txStateNext = S_START;
                    txCntNext   = '0;
                    txShiftNext = wdata[7:0];
                end
            end
            S_START: begin
                txLine = 1'b0;
                if (txCnt == BIT_LAST) begin
                    txStateNext  = S_DATA;
                    txCntNext    = '0;
                    txBitIdxNext = '0;
                end else begin
                    txCntNext = txCnt + CW'(1);
                end
            end
            S_DATA: begin
                txLine = txShift[0];
                if (txCnt == BIT_LAST) begin
                    txCntNext   = '0;
                    txShiftNext = {1'b0, txShift[7:1]};
                    if (txBitIdx == 3'd7) begin
                        txStateNext = S_STOP;
                    end else begin
                        txBitIdxNext = txBitIdx + 3'd1;
                    end
                end else begin
                    txCntNext = txCnt + CW'(1);
                end
            end
            S_STOP: begin
                if (txCnt == BIT_LAST) begin
                    txStateNext = S_IDLE;
                    txCntNext   = '0;
                end else begin
                    txCntNext = txCnt + CW'(1);
                end
            end
            default: txStateNext = S_IDLE;
        endcase
    end

    // ---------------- UART receiver ----------------
    logic [1:0]    rxSync;
    logic          rxLine;
    uartState_t    rxState, rxStateNext;
    logic [CW-1:0] rxCnt, rxCntNext;
    logic [2:0]    rxBitIdx, rxBitIdxNext;
    logic [7:0]    rxShift, rxShiftNext;
    logic          rxPush;

    assign rxLine = rxSync[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rxSync   <= 2'b11;
            rxState  <= S_IDLE;
            rxCnt    <= '0;
            rxBitIdx <= '0;
            rxShift  <= '0;
        end else begin
            rxSync   <= {rxSync[0], uart_rx};
            rxState  <= rxStateNext;
            rxCnt    <= rxCntNext;
            rxBitIdx <= rxBitIdxNext;
            rxShift  <= rxShiftNext;
        end
    end

    always_comb begin
        rxStateNext  = rxState;
        rxCntNext    = rxCnt;
        rxBitIdxNext = rxBitIdx;
        rxShiftNext  = rxShift;
        rxPush       = 1'b0;
        unique case (rxState)
            S_IDLE: begin
                if (!rxLine) begin
                    rxStateNext = S_START;
                    rxCntNext   = '0;
                end
            end
            S_START: begin
                // Half-bit check rejects short low glitches
                if (rxCnt == HALF_LAST) begin
                    rxCntNext    = '0;
                    rxBitIdxNext = '0;
                    rxStateNext  = rxLine ? S_IDLE : S_DATA;
                end else begin
                    rxCntNext = rxCnt + CW'(1);
                end
            end
            S_DATA: begin
                if (rxCnt == BIT_LAST) begin
                    rxCntNext   = '0;
                    rxShiftNext = {rxLine, rxShift[7:1]};
                    if (rxBitIdx == 3'd7) begin
                        rxStateNext = S_STOP;
                    end else begin
                        rxBitIdxNext = rxBitIdx + 3'd1;
                    end
                end else begin
                    rxCntNext = rxCnt + CW'(1);
                end
            end
            S_STOP: begin
                if (rxCnt == BIT_LAST) begin
                    rxPush      = rxLine;
                    rxCntNext   = '0;
                    rxStateNext = S_IDLE;
                end else begin
                    rxCntNext = rxCnt + CW'(1);
                end
            end
            default: rxStateNext = S_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    fifoMem [RX_FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic          fifoEmpty;
    logic          fifoFull;
    logic          doPop;
    logic          doPush;
    logic          ovfSet;
    logic          ovfClr;
    logic          overflow;
    logic [7:0]    fifoHead;

    assign fifoEmpty = (wrPtr == rdPtr);
    assign fifoFull  = (wrPtr[AW] != rdPtr[AW]) &&
                       (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign fifoHead  = fifoMem[rdPtr[AW-1:0]];
    assign doPop     = rdAccess && selRxData && !fifoEmpty;
    assign doPush    = rxPush && (!fifoFull || doPop);
    assign ovfSet    = rxPush && fifoFull && !doPop;
    assign ovfClr    = rdAccess && selRxStat;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) wrPtr <= wrPtr + PW'(1);
            if (doPop)  rdPtr <= rdPtr + PW'(1);
            if (ovfSet) begin
                overflow <= 1'b1;
            end else if (ovfClr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) fifoMem[wrPtr[AW-1:0]] <= rxShift;
    end

    // ---------------- cycle counter ----------------
`ifdef IO_CYCLE_COUNTER_EN
    logic        selCnt;
    logic        cntClr;
    logic [31:0] cycCnt;

    assign selCnt = (regIdx == 6'd4);
    assign cntClr = wrAccess && selCnt;

    always_ff @(posedge clk) begin
        if (rst || cntClr) begin
            cycCnt <= '0;
        end else begin
            cycCnt <= cycCnt + 32'd1;
        end
    end
`endif

    // ---------------- load data ----------------
    logic [31:0] readVal;

    always_comb begin
        readVal = '0;
        unique case (1'b1)
            selTxStat: readVal = {31'b0, txReady};
            selRxStat: readVal = {30'b0, overflow, !fifoEmpty};
            selRxData: readVal = fifoEmpty ? 32'b0 : {24'b0, fifoHead};
`ifdef IO_CYCLE_COUNTER_EN
            selCnt:    readVal = cycCnt;
`endif
            default:   readVal = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= rdAccess ? readVal : 32'b0;
        end
    end

endmodule
